elastic_alu_join: RTL and testbench
===================================

// Module: elastic_alu_join
// PURPOSE
//  Two-operand elastic functional unit for a CGRA processing element; sits directly downstream of
//  two D_FIFO instances and consumes their io_dout/io_dout_v/io_dout_r streams. Joins one token from
//  each input, applies the configured operation and holds the result in a one-entry output register
//  with a valid/ready handshake. Also provides a single-input accumulate mode (reduce N tokens to one).
// PARAMETERS
//  DATA_WIDTH  32  operand/result width
//  OP_WIDTH    4   opcode width
//  CNT_WIDTH   8   accumulate-length counter width
// PORTS
//  clock       in   1           single clock, all state updates on rising edge
//  reset       in   1           synchronous, active-high reset
//  io_op       in   OP_WIDTH    static config opcode (see BEHAVIOUR)
//  io_acc_len  in   CNT_WIDTH   tokens per accumulate result (ACC mode only)
//  io_din1     in   DATA_WIDTH  operand A data (from FIFO io_dout)
//  io_din1_v   in   1           operand A valid
//  io_din1_r   out  1           operand A ready (to FIFO io_dout_r)
//  io_din2     in   DATA_WIDTH  operand B data
//  io_din2_v   in   1           operand B valid
//  io_din2_r   out  1           operand B ready
//  io_dout     out  DATA_WIDTH  result data (registered)
//  io_dout_v   out  1           result valid
//  io_dout_r   in   1           downstream ready
// BEHAVIOUR
//  Reset: io_dout=0, io_dout_v=0, acc=0, cnt=0; io_din1_r=io_din2_r=0 while reset is high.
//  Handshake: transfer on a port when its _v and _r are both 1 at a rising edge.
//  space = !io_dout_v | io_dout_r (output slot empty or draining this cycle).
//  Binary ops (0-11): io_din1_r = space & io_din2_v; io_din2_r = space & io_din1_v; both inputs are
//   consumed in the same cycle or not at all. No path from a lane's own _v to its own _r.
//  Latency: result appears on io_dout/io_dout_v the cycle after the join; full throughput 1/cycle
//   with io_dout_r held 1. io_dout_v=1 with io_dout_r=0 holds io_dout stable.
//  Opcodes: 0 ADD, 1 SUB(A-B), 2 MUL (low DATA_WIDTH bits), 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR logical,
//   8 SRA arithmetic (shift amount = B[log2(DATA_WIDTH)-1:0]), 9 MIN signed, 10 MAX signed,
//   11 LT signed (result 1/0 zero-extended), 12 PASS (A only), 13 ACC, 14-15 reserved (result 0,
//   handshakes as binary ops). ADD/SUB/MUL/ACC wrap modulo 2^DATA_WIDTH.
//  PASS/ACC: io_din2_r=0 (B never consumed); io_din1_r = space.
//  PASS: each A handshake loads A into the output register.
//  ACC FSM, states ACC_RUN (cnt<len-1) and ACC_LAST (cnt==len-1); len = io_acc_len, 0 treated as 1:
//   A handshake in ACC_RUN: acc<=acc+A, cnt<=cnt+1, no output; in ACC_LAST: io_dout<=acc+A,
//   io_dout_v<=1, acc<=0, cnt<=0. In ACC_RUN io_din1_r=1 regardless of space.
//  io_op/io_acc_len are changed only when no tokens are in flight; any cycle with io_op!=ACC
//   clears acc and cnt (partial accumulation discarded).
//  Reset mid-operation: output token, acc and cnt are dropped; no handshake completes in a reset cycle.
// TESTING
//  T1 reset: reset=1 2 cycles with both inputs valid -> io_dout_v=0, io_din1_r=io_din2_r=0, io_dout=0.
//  T2 ADD stream: op=0, A=1,3,5,7,9 / B=10,20,30,40,50, io_dout_r=1 -> dout 11,23,35,47,59 on
//   consecutive cycles, each 1 cycle after its join.
//  T3 join skew: op=1, A valid at cycle 0, B valid at cycle 3 (A=9,B=4) -> io_din1_r low cycles 0-2,
//   single transfer at cycle 3, dout=5 valid at cycle 4; no duplicate token.
//  T4 backpressure: op=2, A=0x10000,B=0x10000, io_dout_r=0 for 4 cycles -> dout=0 (wrap) held stable,
//   both _r low while full; releasing io_dout_r drains and accepts next pair same cycle.
//  T5 ACC: op=13, len=4, A=1,2,3,4,5,6,7,8, B valid always -> dout 10 then 26; io_din2_r never 1;
//   len=0 -> every A passes through unchanged.
//  T6 signed/shift: MIN(-3,2)=-3, LT(-1,0)=1, SRA(0x80000000,4)=0xF8000000, SHR same=0x08000000, op=15 -> 0.

Source files
------------

// File: rtl/elastic_alu_join.sv
// elastic_alu_join: joins one token from each operand stream, applies io_op, registers the result.
// Ports: clock/reset (sync, active-high); io_op/io_acc_len static config;
//        io_din1*/io_din2* operand streams (valid/ready); io_dout* registered result stream.
module elastic_alu_join #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [OP_WIDTH-1:0]   io_op,
    input  logic [CNT_WIDTH-1:0]  io_acc_len,
    input  logic [DATA_WIDTH-1:0] io_din1,
    input  logic                  io_din1_v,
    output logic                  io_din1_r,
    input  logic [DATA_WIDTH-1:0] io_din2,
    input  logic                  io_din2_v,
    output logic                  io_din2_r,
    output logic [DATA_WIDTH-1:0] io_dout,
    output logic                  io_dout_v,
    input  logic                  io_dout_r
);
    localparam int SW = $clog2(DATA_WIDTH);
    typedef enum logic {ACC_RUN, ACC_LAST} acc_state_e;
    acc_state_e            state;
    logic [DATA_WIDTH-1:0] dout_q, dout_d, acc_q, acc_d, alu, acc_sum;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, len;
    logic [SW-1:0]         sh;
    logic                  dout_v_q, dout_v_d, space, is_pass, is_acc, fire, load;
    always_comb begin
        sh = io_din2[SW-1:0];
        alu = '0;
        case (int'(io_op))
            0:  alu = io_din1 + io_din2;
            1:  alu = io_din1 - io_din2;
            2:  alu = io_din1 * io_din2;
            3:  alu = io_din1 & io_din2;
            4:  alu = io_din1 | io_din2;
            5:  alu = io_din1 ^ io_din2;
            6:  alu = io_din1 << sh;
            7:  alu = io_din1 >> sh;
            8:  alu = $signed(io_din1) >>> sh;
            9:  alu = ($signed(io_din1) < $signed(io_din2)) ? io_din1 : io_din2;
            10: alu = ($signed(io_din1) < $signed(io_din2)) ? io_din2 : io_din1;
            11: alu = {{(DATA_WIDTH-1){1'b0}}, $signed(io_din1) < $signed(io_din2)};
            12: alu = io_din1;
            default: alu = '0;
        endcase
    end
    always_comb begin
        is_pass = int'(io_op) == 12;
        is_acc = int'(io_op) == 13;
        // A length of zero behaves as one: every token closes its own group.
        len = (io_acc_len == '0) ? CNT_WIDTH'(1) : io_acc_len;
        // >= keeps the FSM from running away if cnt ever exceeds the last index.
        state = (cnt_q >= len - CNT_WIDTH'(1)) ? ACC_LAST : ACC_RUN;
        space = !dout_v_q | io_dout_r;
        // Each lane's ready depends only on the other lane's valid, so the join never
        // creates a combinational loop through an upstream FIFO.
        io_din1_r = reset ? 1'b0 : is_acc ? (state == ACC_RUN) | space : is_pass ? space : space & io_din2_v;
        io_din2_r = (reset | is_acc | is_pass) ? 1'b0 : space & io_din1_v;
        fire = io_din1_v & io_din1_r;
        acc_sum = acc_q + io_din1;
        load = fire & !(is_acc & state == ACC_RUN);
        dout_d = load ? (is_acc ? acc_sum : alu) : dout_q;
        dout_v_d = load | (dout_v_q & !io_dout_r);
        acc_d = (!is_acc || (fire && state == ACC_LAST)) ? '0 : fire ? acc_sum : acc_q;
        cnt_d = (!is_acc || (fire && state == ACC_LAST)) ? '0 : fire ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            dout_q <= '0;
            dout_v_q <= 1'b0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            dout_q <= dout_d;
            dout_v_q <= dout_v_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
    assign io_dout = dout_q;
    assign io_dout_v = dout_v_q;
endmodule

// File: tb/tb_elastic_alu_join.sv
// tb_elastic_alu_join: directed and randomized checks of elastic_alu_join against a token-level model.
module tb_elastic_alu_join;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  op = '0;
    logic [7:0]  acc_len = 8'd1;
    logic [31:0] din1 = '0, din2 = '0, dout;
    logic        din1_v = 1'b0, din2_v = 1'b0, din1_r, din2_r, dout_v, dout_r = 1'b1;
    int          tests = 0, fails = 0;

    elastic_alu_join dut (
        .clock(clock), .reset(reset), .io_op(op), .io_acc_len(acc_len),
        .io_din1(din1), .io_din1_v(din1_v), .io_din1_r(din1_r),
        .io_din2(din2), .io_din2_v(din2_v), .io_din2_r(din2_r),
        .io_dout(dout), .io_dout_v(dout_v), .io_dout_r(dout_r)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_op(input int o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        int s;
        sa = a;
        sb = b;
        s = int'(b % 32);
        case (o)
            0: return a + b;
            1: return a - b;
            2: return 32'((64'(a) * 64'(b)) % 64'h1_0000_0000);
            3: return a & b;
            4: return a | b;
            5: return a ^ b;
            6: return a << s;
            7: return a >> s;
            8: return sa >>> s;
            9: return (sa < sb) ? a : b;
            10: return (sa > sb) ? a : b;
            11: return (sa < sb) ? 32'd1 : 32'd0;
            12: return a;
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle();
        din1_v = 1'b0;
        din2_v = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        din1 = 32'h55;
        din2 = 32'h66;
        din1_v = 1'b1;
        din2_v = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock); #1;
            tests++; if (dout_v !== 1'b0) begin fails++; $display("FAIL reset_v got %b exp 0", dout_v); end
            tests++; if (din1_r !== 1'b0) begin fails++; $display("FAIL reset_r1 got %b exp 0", din1_r); end
            tests++; if (din2_r !== 1'b0) begin fails++; $display("FAIL reset_r2 got %b exp 0", din2_r); end
            tests++; if (dout !== 32'd0) begin fails++; $display("FAIL reset_dout got %h exp 0", dout); end
        end
        @(negedge clock);
        idle();
        reset = 1'b0;
    endtask

    task automatic test_add_stream();
        logic [31:0] a[5], b[5];
        a = '{1, 3, 5, 7, 9};
        b = '{10, 20, 30, 40, 50};
        op = 4'd0;
        dout_r = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clock);
            if (i < 5) begin din1 = a[i]; din2 = b[i]; din1_v = 1'b1; din2_v = 1'b1; end
            else idle();
            #1;
            if (i > 0) begin
                tests++; if (dout_v !== 1'b1) begin fails++; $display("FAIL add_v[%0d] got %b exp 1", i - 1, dout_v); end
                tests++; if (dout !== a[i-1] + b[i-1]) begin fails++; $display("FAIL add_dout[%0d] got %0d exp %0d", i - 1, dout, a[i-1] + b[i-1]); end
            end
            if (i < 5) begin
                tests++; if ({din1_r, din2_r} !== 2'b11) begin fails++; $display("FAIL add_ready[%0d] got %b exp 11", i, {din1_r, din2_r}); end
            end
        end
        @(negedge clock); #1;
        tests++; if (dout_v !== 1'b0) begin fails++; $display("FAIL add_drain got %b exp 0", dout_v); end
    endtask

    task automatic test_join_skew();
        op = 4'd1;
        dout_r = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            din1 = 32'd9; din1_v = 1'b1;
            din2 = 32'd4; din2_v = (c == 3);
            #1;
            tests++; if (din1_r !== (c == 3)) begin fails++; $display("FAIL skew_r1[%0d] got %b exp %b", c, din1_r, c == 3); end
            tests++; if (din2_r !== 1'b1) begin fails++; $display("FAIL skew_r2[%0d] got %b exp 1", c, din2_r); end
            tests++; if (dout_v !== 1'b0) begin fails++; $display("FAIL skew_early_v[%0d] got %b exp 0", c, dout_v); end
        end
        @(negedge clock);
        idle();
        #1;
        tests++; if (dout_v !== 1'b1 || dout !== 32'd5) begin fails++; $display("FAIL skew_dout got v=%b %0d exp v=1 5", dout_v, dout); end
        @(negedge clock); #1;
        tests++; if (dout_v !== 1'b0) begin fails++; $display("FAIL skew_dup got %b exp 0", dout_v); end
    endtask

    task automatic test_backpressure();
        op = 4'd2;
        dout_r = 1'b0;
        @(negedge clock);
        din1 = 32'h10000; din2 = 32'h10000; din1_v = 1'b1; din2_v = 1'b1;
        #1;
        tests++; if ({din1_r, din2_r} !== 2'b11) begin fails++; $display("FAIL bp_accept got %b exp 11", {din1_r, din2_r}); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            din1 = 32'd3; din2 = 32'd5;
            #1;
            tests++; if (dout_v !== 1'b1 || dout !== 32'd0) begin fails++; $display("FAIL bp_hold[%0d] got v=%b %h exp v=1 0", k, dout_v, dout); end
            tests++; if ({din1_r, din2_r} !== 2'b00) begin fails++; $display("FAIL bp_full_r[%0d] got %b exp 00", k, {din1_r, din2_r}); end
        end
        @(negedge clock);
        dout_r = 1'b1;
        #1;
        tests++; if ({din1_r, din2_r} !== 2'b11) begin fails++; $display("FAIL bp_release_r got %b exp 11", {din1_r, din2_r}); end
        @(negedge clock);
        idle();
        #1;
        tests++; if (dout_v !== 1'b1 || dout !== 32'd15) begin fails++; $display("FAIL bp_next got v=%b %0d exp v=1 15", dout_v, dout); end
        @(negedge clock); #1;
        tests++; if (dout_v !== 1'b0) begin fails++; $display("FAIL bp_drain got %b exp 0", dout_v); end
    endtask

    task automatic test_mid_reset();
        op = 4'd0;
        dout_r = 1'b0;
        @(negedge clock);
        din1 = 32'd2; din2 = 32'd2; din1_v = 1'b1; din2_v = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        #1;
        tests++; if ({din1_r, din2_r} !== 2'b00) begin fails++; $display("FAIL midrst_r got %b exp 00", {din1_r, din2_r}); end
        @(negedge clock); #1;
        tests++; if (dout_v !== 1'b0 || dout !== 32'd0) begin fails++; $display("FAIL midrst_out got v=%b %h exp v=0 0", dout_v, dout); end
        reset = 1'b0;
        idle();
        dout_r = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_acc();
        logic [31:0] sum, exp_d, a;
        int cnt;
        logic exp_v;
        op = 4'd13;
        acc_len = 8'd4;
        dout_r = 1'b1;
        din2 = 32'hBAD;
        din2_v = 1'b1;
        sum = 0; cnt = 0; exp_v = 1'b0; exp_d = 0;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clock);
            din1 = i + 1;
            din1_v = (i < 8);
            #1;
            tests++; if (dout_v !== exp_v) begin fails++; $display("FAIL acc_v[%0d] got %b exp %b", i, dout_v, exp_v); end
            if (exp_v) begin tests++; if (dout !== exp_d) begin fails++; $display("FAIL acc_dout[%0d] got %0d exp %0d", i, dout, exp_d); end end
            tests++; if (din2_r !== 1'b0) begin fails++; $display("FAIL acc_r2[%0d] got %b exp 0", i, din2_r); end
            if (i < 8) begin tests++; if (din1_r !== 1'b1) begin fails++; $display("FAIL acc_r1[%0d] got %b exp 1", i, din1_r); end end
            exp_v = 1'b0;
            if (i < 8) begin
                sum += i + 1;
                cnt++;
                if (cnt == 4) begin exp_v = 1'b1; exp_d = sum; sum = 0; cnt = 0; end
            end
        end
        acc_len = 8'd0;
        exp_v = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clock);
            a = $urandom;
            din1 = a;
            din1_v = (i < 4);
            #1;
            tests++; if (dout_v !== exp_v) begin fails++; $display("FAIL len0_v[%0d] got %b exp %b", i, dout_v, exp_v); end
            if (exp_v) begin tests++; if (dout !== exp_d) begin fails++; $display("FAIL len0_dout[%0d] got %h exp %h", i, dout, exp_d); end end
            exp_v = (i < 4);
            exp_d = a;
        end
        // Partial accumulation must be discarded when the opcode leaves ACC.
        acc_len = 8'd4;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            din1 = 32'd100;
            din1_v = 1'b1;
        end
        @(negedge clock);
        idle();
        op = 4'd0;
        @(negedge clock);
        op = 4'd13;
        din2_v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            din1 = 32'd1;
            din1_v = 1'b1;
        end
        @(negedge clock);
        idle();
        #1;
        tests++; if (dout_v !== 1'b1 || dout !== 32'd4) begin fails++; $display("FAIL acc_clear got v=%b %0d exp v=1 4", dout_v, dout); end
        @(negedge clock);
    endtask

    task automatic test_signed_shift();
        logic [3:0]  ops[8];
        logic [31:0] av[8], bv[8], ev[8];
        ops = '{4'd9, 4'd11, 4'd8, 4'd7, 4'd15, 4'd10, 4'd12, 4'd6};
        av = '{-32'sd3, -32'sd1, 32'h8000_0000, 32'h8000_0000, 32'd5, -32'sd3, 32'hDEAD, 32'h1};
        bv = '{32'd2, 32'd0, 32'd4, 32'd4, 32'd6, 32'd2, 32'd1, 32'd35};
        ev = '{-32'sd3, 32'd1, 32'hF800_0000, 32'h0800_0000, 32'd0, 32'd2, 32'hDEAD, 32'h8};
        dout_r = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            op = ops[i];
            din1 = av[i]; din2 = bv[i]; din1_v = 1'b1; din2_v = 1'b1;
            @(negedge clock);
            idle();
            #1;
            tests++; if (dout_v !== 1'b1 || dout !== ev[i]) begin fails++; $display("FAIL op%0d got v=%b %h exp v=1 %h", ops[i], dout_v, dout, ev[i]); end
        end
        @(negedge clock);
    endtask

    task automatic test_random_stream();
        logic [3:0]  ops[6];
        logic [31:0] a[30], b[30], e[30];
        logic [31:0] prev_d;
        logic        hold, sp;
        int          ia, ib, oi;
        ops = '{4'd0, 4'd2, 4'd8, 4'd9, 4'd12, 4'd14};
        for (int r = 0; r < 6; r++) begin
            op = ops[r];
            for (int i = 0; i < 30; i++) begin
                a[i] = $urandom;
                b[i] = (r == 2) ? 32'($urandom_range(0, 63)) : $urandom;
                e[i] = ref_op(int'(ops[r]), a[i], b[i]);
            end
            ia = 0; ib = 0; oi = 0; hold = 1'b0; prev_d = 0;
            for (int cyc = 0; cyc < 1000 && oi < 30; cyc++) begin
                @(negedge clock);
                din1_v = (ia < 30) && ($urandom_range(0, 3) != 0);
                din1 = (ia < 30) ? a[ia] : 32'd0;
                din2_v = (ib < 30) && ($urandom_range(0, 3) != 0);
                din2 = (ib < 30) ? b[ib] : 32'd0;
                dout_r = ($urandom_range(0, 3) != 0);
                #1;
                sp = !dout_v | dout_r;
                if (hold) begin
                    tests++; if (dout_v !== 1'b1 || dout !== prev_d) begin fails++; $display("FAIL rnd_stable op%0d got v=%b %h exp v=1 %h", op, dout_v, dout, prev_d); end
                end
                if (op == 4'd12) begin
                    tests++; if (din2_r !== 1'b0) begin fails++; $display("FAIL rnd_pass_r2 got %b exp 0", din2_r); end
                    tests++; if (din1_r !== sp) begin fails++; $display("FAIL rnd_pass_r1 got %b exp %b", din1_r, sp); end
                end else begin
                    tests++; if (din1_r !== (sp & din2_v)) begin fails++; $display("FAIL rnd_r1 op%0d got %b exp %b", op, din1_r, sp & din2_v); end
                    tests++; if (din2_r !== (sp & din1_v)) begin fails++; $display("FAIL rnd_r2 op%0d got %b exp %b", op, din2_r, sp & din1_v); end
                end
                if (dout_v && dout_r) begin
                    tests++; if (dout !== e[oi]) begin fails++; $display("FAIL rnd_dout op%0d[%0d] got %h exp %h", op, oi, dout, e[oi]); end
                    oi++;
                end
                hold = dout_v & !dout_r;
                prev_d = dout;
                if (din1_v && din1_r) ia++;
                if (din2_v && din2_r) ib++;
            end
            tests++; if (oi != 30) begin fails++; $display("FAIL rnd_count op%0d got %0d exp 30", op, oi); end
            @(negedge clock);
            idle();
            dout_r = 1'b1;
            @(negedge clock);
        end
    endtask

    task automatic test_random_acc();
        logic [31:0] a[40], e[40];
        int          len, n, ia, oi;
        logic        sp, exp_r1;
        op = 4'd13;
        for (int r = 0; r < 3; r++) begin
            len = $urandom_range(1, 5);
            acc_len = 8'(len);
            n = len * 6;
            for (int g = 0; g < 6; g++) begin
                e[g] = 0;
                for (int k = 0; k < len; k++) begin
                    a[g * len + k] = $urandom;
                    e[g] += a[g * len + k];
                end
            end
            ia = 0; oi = 0;
            for (int cyc = 0; cyc < 1000 && oi < 6; cyc++) begin
                @(negedge clock);
                din1_v = (ia < n) && ($urandom_range(0, 3) != 0);
                din1 = (ia < n) ? a[ia] : 32'd0;
                din2_v = ($urandom_range(0, 1) != 0);
                din2 = $urandom;
                dout_r = ($urandom_range(0, 2) != 0);
                #1;
                sp = !dout_v | dout_r;
                exp_r1 = ((ia % len) != len - 1) | sp;
                tests++; if (din2_r !== 1'b0) begin fails++; $display("FAIL racc_r2 got %b exp 0", din2_r); end
                tests++; if (din1_r !== exp_r1) begin fails++; $display("FAIL racc_r1 len%0d got %b exp %b", len, din1_r, exp_r1); end
                if (dout_v && dout_r) begin
                    tests++; if (dout !== e[oi]) begin fails++; $display("FAIL racc_dout len%0d[%0d] got %h exp %h", len, oi, dout, e[oi]); end
                    oi++;
                end
                if (din1_v && din1_r) ia++;
            end
            tests++; if (oi != 6) begin fails++; $display("FAIL racc_count len%0d got %0d exp 6", len, oi); end
            @(negedge clock);
            idle();
            dout_r = 1'b1;
            @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_add_stream();
        test_join_skew();
        test_backpressure();
        test_mid_reset();
        test_acc();
        test_signed_shift();
        test_random_stream();
        test_random_acc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
